rot_xor_engine: RTL and testbench
=================================

Name: rot_xor_engine

Overview:
Sequential, parametrised rotate/shift-XOR engine, the generalised successor to the fixed-amount rotators. It computes up to three rotate/shift terms of one input word, one term per clock, and XORs them into an accumulator. This covers SHA-256 sigma0/sigma1/Sigma0/Sigma1 and any single rotate or shift. Valid/ready handshake on input and output, sitting between the message-schedule/round logic and its operand registers.

Parameters:
WIDTH, 32, data word width; power of two, >= 4
AW, $clog2(WIDTH), shift-amount width (derived; not overridden)

Ports:
clk  input  1  clock; all state on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  request valid
in_ready  output  1  engine can accept a request
in_data  input  WIDTH  operand word
amt0, amt1, amt2  input  AW each  shift/rotate amount per term
op0, op1, op2  input  2 each  term op: 00 OFF, 01 ROTR, 10 SHR, 11 ROTL
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_data  output  WIDTH  XOR of the three term results

Behaviour:
- Reset is asynchronous on rst_n low: state IDLE, out_valid=0, out_data=0, accumulator=0, term index=0. in_ready = (state==IDLE), so it reads 1 during and after reset. Inputs are not sampled while rst_n is low.
- FSM states are IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid at an edge: capture in_data, amt0..2 and op0..2 into registers; clear accumulator; index=0; go to CALC.
- CALC:
  - in_ready=0.
  - Each edge: acc <= acc ^ term(op[index], data_q, amt[index]); index++.
  - After the index-2 update, go to DONE.
  - Exactly 3 CALC edges, including for OFF terms (fixed latency).
- DONE:
  - out_valid=1; out_data=acc, held stable until handshake.
  - On out_ready at an edge: out_valid falls, go to IDLE.
  - in_valid is ignored while not in IDLE.
- Latency: request accepted at edge T; out_valid is high in the cycle after edge T+3. Minimum issue interval is 5 cycles (accept, 3 CALC, 1 DONE handshake); no overlap of requests.
- Term rules:
  - ROTR: bit i of result = data[(i+amt) mod WIDTH].
  - ROTL: bit i = data[(i-amt) mod WIDTH].
  - SHR: logical right shift, zero fill.
  - OFF: contributes 0.
- Boundary cases:
  - amt=0 gives identity for ROTR/ROTL/SHR.
  - amt=WIDTH-1 is legal.
  - All ops OFF gives out_data=0.
  - Captured operands are immune to input changes after acceptance.
- Reset mid-CALC or mid-DONE aborts the operation; no result is emitted; the next request after release behaves normally.
- out_data outside DONE holds the last result (0 after reset); consumers use it only when out_valid=1.

Decomposition:
- Package rot_pkg:
  - op_e enum (OP_OFF, OP_ROTR, OP_SHR, OP_ROTL).
  - state_e enum.
  - SHA-256 amount/op constants: SIG0 = ROTR7/ROTR18/SHR3; SIG1 = ROTR17/ROTR19/SHR10; BSIG0 = ROTR2/ROTR13/ROTR22; BSIG1 = ROTR6/ROTR11/ROTR25.
- One sub-module, rot_term: combinational, parametrised by WIDTH, inputs data/amt/op, output one term. Instantiated once and muxed by index.
- Top-level rot_xor_engine holds the FSM, captured operands and accumulator.

Test Plan:
- SIG0 constants, in_data=0x00000001 -> out_data=0x02004000, out_valid in the cycle after edge T+3.
- SIG1 constants, in_data=0x80000000 -> out_data=0x00205000.
- Single term op0=ROTL amt0=4, op1=op2=OFF, in_data=0x12345678 -> 0x23456781. Same word with ROTR amt0=0 -> 0x12345678. All OFF -> 0x00000000.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid with in_valid=1 and in_data changing -> out_data stable, in_ready=0, no new capture. Handshake -> IDLE, in_ready=1 next cycle.
- Reset mid-CALC (rst_n low one cycle after acceptance) -> out_valid=0, out_data=0 immediately. Next request BSIG0 on 0x00000001 -> 0x40080400.
- Back-to-back requests, in_valid held high with out_ready=1 -> second request accepted exactly 5 cycles after the first; both results correct and in order.

Source files
------------

// File: rtl/rot_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rot_pkg
//  Description : Shared types and SHA-256 term constants for the
//                rotate/shift-XOR engine.
//  Revision    : 1.0 - initial release
// ============================================================================
package rot_pkg;

    // Per-term operation encoding, matching the op0..op2 port encoding
    typedef enum logic [1:0] {
        OP_OFF  = 2'b00,
        OP_ROTR = 2'b01,
        OP_SHR  = 2'b10,
        OP_ROTL = 2'b11
    } op_e;

    // Engine control states
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // SHA-256 small sigma0: ROTR7 ^ ROTR18 ^ SHR3
    localparam logic [4:0] SIG0_AMT0  = 5'd7;
    localparam logic [4:0] SIG0_AMT1  = 5'd18;
    localparam logic [4:0] SIG0_AMT2  = 5'd3;
    localparam op_e        SIG0_OP0   = OP_ROTR;
    localparam op_e        SIG0_OP1   = OP_ROTR;
    localparam op_e        SIG0_OP2   = OP_SHR;

    // SHA-256 small sigma1: ROTR17 ^ ROTR19 ^ SHR10
    localparam logic [4:0] SIG1_AMT0  = 5'd17;
    localparam logic [4:0] SIG1_AMT1  = 5'd19;
    localparam logic [4:0] SIG1_AMT2  = 5'd10;
    localparam op_e        SIG1_OP0   = OP_ROTR;
    localparam op_e        SIG1_OP1   = OP_ROTR;
    localparam op_e        SIG1_OP2   = OP_SHR;

    // SHA-256 big Sigma0: ROTR2 ^ ROTR13 ^ ROTR22
    localparam logic [4:0] BSIG0_AMT0 = 5'd2;
    localparam logic [4:0] BSIG0_AMT1 = 5'd13;
    localparam logic [4:0] BSIG0_AMT2 = 5'd22;
    localparam op_e        BSIG0_OP0  = OP_ROTR;
    localparam op_e        BSIG0_OP1  = OP_ROTR;
    localparam op_e        BSIG0_OP2  = OP_ROTR;

    // SHA-256 big Sigma1: ROTR6 ^ ROTR11 ^ ROTR25
    localparam logic [4:0] BSIG1_AMT0 = 5'd6;
    localparam logic [4:0] BSIG1_AMT1 = 5'd11;
    localparam logic [4:0] BSIG1_AMT2 = 5'd25;
    localparam op_e        BSIG1_OP0  = OP_ROTR;
    localparam op_e        BSIG1_OP1  = OP_ROTR;
    localparam op_e        BSIG1_OP2  = OP_ROTR;

endpackage
`default_nettype wire

// File: rtl/rot_term.sv
`default_nettype none
// ============================================================================
//  Module      : rot_term
//  Description : Combinational single-term evaluator: rotate right, rotate
//                left, logical shift right or off, by a variable amount.
//  Revision    : 1.0 - initial release
// ============================================================================
module rot_term
    import rot_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int AW    = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] data,
    input  logic [AW-1:0]    amt,
    input  op_e              op,
    output logic [WIDTH-1:0] term
);

    logic [WIDTH-1:0] w_rotr;
    logic [WIDTH-1:0] w_rotl;

    // WIDTH is a power of two, so AW-bit index arithmetic wraps mod WIDTH
    // and gives the rotate source bit directly.
    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_bit
            localparam logic [AW-1:0] C_BIT = AW'(i);
            assign w_rotr[i] = data[C_BIT + amt];
            assign w_rotl[i] = data[C_BIT - amt];
        end
    endgenerate

    // Select the requested operation; OFF contributes nothing to the XOR
    always_comb begin
        term = '0;
        case (op)
            OP_ROTR: term = w_rotr;
            OP_SHR:  term = data >> amt;
            OP_ROTL: term = w_rotl;
            default: term = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/rot_xor_engine.sv
`default_nettype none
// ============================================================================
//  Module      : rot_xor_engine
//  Description : Sequential three-term rotate/shift-XOR engine with
//                valid/ready handshakes; one term folded per clock.
//  Revision    : 1.0 - initial release
// ============================================================================
module rot_xor_engine
    import rot_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int AW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AW-1:0]    amt0,
    input  logic [AW-1:0]    amt1,
    input  logic [AW-1:0]    amt2,
    input  logic [1:0]       op0,
    input  logic [1:0]       op1,
    input  logic [1:0]       op2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    state_e           r_state;
    state_e           w_next_state;
    logic [WIDTH-1:0] r_data;
    logic [AW-1:0]    r_amt0, r_amt1, r_amt2;
    op_e              r_op0, r_op1, r_op2;
    logic [WIDTH-1:0] r_acc;
    logic [1:0]       r_idx;
    logic [WIDTH-1:0] r_out;

    logic [AW-1:0]    w_sel_amt;
    op_e              w_sel_op;
    logic [WIDTH-1:0] w_term;
    logic [WIDTH-1:0] w_acc_next;

    // Pick the captured amount/op for the term being folded this cycle
    always_comb begin
        w_sel_amt = r_amt2;
        w_sel_op  = r_op2;
        case (r_idx)
            2'd0:    begin w_sel_amt = r_amt0; w_sel_op = r_op0; end
            2'd1:    begin w_sel_amt = r_amt1; w_sel_op = r_op1; end
            default: begin w_sel_amt = r_amt2; w_sel_op = r_op2; end
        endcase
    end

    rot_term #(
        .WIDTH (WIDTH)
    ) u_term (
        .data (r_data),
        .amt  (w_sel_amt),
        .op   (w_sel_op),
        .term (w_term)
    );

    assign w_acc_next = r_acc ^ w_term;
    assign out_data   = r_out;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and handshake outputs; CALC always spends exactly 3 cycles
    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next_state = ST_CALC;
            end
            ST_CALC: begin
                if (r_idx == 2'd2) w_next_state = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Operand capture, accumulation and result latch; the result register
    // only changes on the final fold so out_data holds between requests.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
            r_amt0 <= '0;
            r_amt1 <= '0;
            r_amt2 <= '0;
            r_op0  <= OP_OFF;
            r_op1  <= OP_OFF;
            r_op2  <= OP_OFF;
            r_acc  <= '0;
            r_idx  <= 2'd0;
            r_out  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_data <= in_data;
                        r_amt0 <= amt0;
                        r_amt1 <= amt1;
                        r_amt2 <= amt2;
                        r_op0  <= op_e'(op0);
                        r_op1  <= op_e'(op1);
                        r_op2  <= op_e'(op2);
                        r_acc  <= '0;
                        r_idx  <= 2'd0;
                    end
                end
                ST_CALC: begin
                    r_acc <= w_acc_next;
                    r_idx <= r_idx + 2'd1;
                    if (r_idx == 2'd2) r_out <= w_acc_next;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rot_xor_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rot_xor_engine
//  Description : Directed self-checking bench for rot_xor_engine with
//                hand-computed SHA-256 and single-term vectors.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rot_xor_engine;
    import rot_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [4:0]  amt0, amt1, amt2;
    logic [1:0]  op0, op1, op2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;

    int n_checks;
    int n_fail;

    rot_xor_engine #(
        .WIDTH (32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .amt0      (amt0),
        .amt1      (amt1),
        .amt2      (amt2),
        .op0       (op0),
        .op1       (op1),
        .op2       (op2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request, scramble the inputs after acceptance, measure
    // latency and check the result; optionally complete the handshake.
    task automatic do_req(input string tag, input logic [31:0] d,
                          input logic [1:0] o0, input logic [4:0] a0,
                          input logic [1:0] o1, input logic [4:0] a1,
                          input logic [1:0] o2, input logic [4:0] a2,
                          input logic [31:0] exp, input bit hs);
        int cyc;
        in_valid = 1'b1;
        in_data  = d;
        op0 = o0; amt0 = a0;
        op1 = o1; amt1 = a1;
        op2 = o2; amt2 = a2;
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        in_data  = ~d;
        op0 = ~o0; amt0 = ~a0;
        op1 = ~o1; amt1 = ~a1;
        op2 = ~o2; amt2 = ~a2;
        cyc = 0;
        while (!out_valid && cyc < 10) begin
            tick();
            cyc++;
        end
        check({tag, "_latency"}, 32'(cyc), 32'd3);
        check({tag, "_data"}, out_data, exp);
        if (hs) begin
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            check({tag, "_ov_after_hs"}, {31'd0, out_valid}, 32'd0);
            check({tag, "_ir_after_hs"}, {31'd0, in_ready}, 32'd1);
        end
    endtask

    logic [31:0] held;
    logic        ov_log [1:9];
    logic        ir_log [1:9];
    logic [31:0] od_log [1:9];

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 32'hDEADBEEF;
        amt0 = 5'd0; amt1 = 5'd0; amt2 = 5'd0;
        op0  = 2'b00; op1 = 2'b00; op2 = 2'b00;
        out_ready = 1'b0;

        // Reset state, with in_valid asserted to show it is not sampled
        in_valid = 1'b1;
        tick();
        tick();
        check("rst_in_ready",  {31'd0, in_ready},  32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data",  out_data,           32'd0);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        tick();
        check("post_rst_out_valid", {31'd0, out_valid}, 32'd0);

        // SHA-256 functions and single-term boundaries
        do_req("sig0", 32'h00000001, SIG0_OP0, SIG0_AMT0, SIG0_OP1, SIG0_AMT1,
               SIG0_OP2, SIG0_AMT2, 32'h02004000, 1'b1);
        do_req("sig1", 32'h80000000, SIG1_OP0, SIG1_AMT0, SIG1_OP1, SIG1_AMT1,
               SIG1_OP2, SIG1_AMT2, 32'h00205000, 1'b1);
        do_req("rotl4", 32'h12345678, OP_ROTL, 5'd4, OP_OFF, 5'd9, OP_OFF, 5'd1,
               32'h23456781, 1'b1);
        do_req("rotr0", 32'h12345678, OP_ROTR, 5'd0, OP_OFF, 5'd0, OP_OFF, 5'd0,
               32'h12345678, 1'b1);
        do_req("shr0", 32'h12345678, OP_OFF, 5'd3, OP_SHR, 5'd0, OP_OFF, 5'd0,
               32'h12345678, 1'b1);
        do_req("all_off", 32'h12345678, OP_OFF, 5'd4, OP_OFF, 5'd7, OP_OFF, 5'd9,
               32'h00000000, 1'b1);
        do_req("rotr31", 32'h00000001, OP_OFF, 5'd0, OP_OFF, 5'd0, OP_ROTR, 5'd31,
               32'h00000002, 1'b1);
        do_req("shr31_rotl31", 32'h80000001, OP_SHR, 5'd31, OP_ROTL, 5'd31, OP_OFF, 5'd0,
               32'hC0000001, 1'b1);

        // Backpressure: result held, new requests ignored while in DONE
        do_req("bp", 32'h00000001, SIG0_OP0, SIG0_AMT0, SIG0_OP1, SIG0_AMT1,
               SIG0_OP2, SIG0_AMT2, 32'h02004000, 1'b0);
        held = out_data;
        in_valid = 1'b1;
        op0 = OP_ROTL; amt0 = 5'd1;
        for (int k = 0; k < 5; k++) begin
            in_data = 32'h1111_0000 + 32'(k);
            tick();
            check("bp_data_stable", out_data, held);
            check("bp_in_ready",  {31'd0, in_ready},  32'd0);
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_hs_out_valid", {31'd0, out_valid}, 32'd0);
        check("bp_hs_in_ready",  {31'd0, in_ready},  32'd1);
        for (int k = 0; k < 4; k++) tick();
        check("bp_no_capture", {31'd0, out_valid}, 32'd0);

        // Reset one cycle after acceptance aborts the operation
        in_valid = 1'b1;
        in_data  = 32'h00000001;
        op0 = BSIG1_OP0; amt0 = BSIG1_AMT0;
        op1 = BSIG1_OP1; amt1 = BSIG1_AMT1;
        op2 = BSIG1_OP2; amt2 = BSIG1_AMT2;
        tick();
        in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_out_data",  out_data,           32'd0);
        check("midrst_in_ready",  {31'd0, in_ready},  32'd1);
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        check("midrst_no_result", {31'd0, out_valid}, 32'd0);
        do_req("bsig0", 32'h00000001, BSIG0_OP0, BSIG0_AMT0, BSIG0_OP1, BSIG0_AMT1,
               BSIG0_OP2, BSIG0_AMT2, 32'h40080400, 1'b1);

        // Back-to-back: in_valid and out_ready held high
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h00000001;
        op0 = BSIG1_OP0; amt0 = BSIG1_AMT0;
        op1 = BSIG1_OP1; amt1 = BSIG1_AMT1;
        op2 = BSIG1_OP2; amt2 = BSIG1_AMT2;
        tick();
        in_data = 32'h80000000;
        op0 = SIG1_OP0; amt0 = SIG1_AMT0;
        op1 = SIG1_OP1; amt1 = SIG1_AMT1;
        op2 = SIG1_OP2; amt2 = SIG1_AMT2;
        for (int c = 1; c <= 9; c++) begin
            tick();
            ov_log[c] = out_valid;
            ir_log[c] = in_ready;
            od_log[c] = out_data;
            if (c == 5) in_valid = 1'b0;
        end
        out_ready = 1'b0;
        check("b2b_first_valid",  {31'd0, ov_log[3]}, 32'd1);
        check("b2b_first_data",   od_log[3],          32'h04200080);
        check("b2b_busy",         {31'd0, ir_log[2]}, 32'd0);
        check("b2b_idle_slot",    {31'd0, ir_log[4]}, 32'd1);
        check("b2b_gap",          {31'd0, ov_log[7]}, 32'd0);
        check("b2b_second_valid", {31'd0, ov_log[8]}, 32'd1);
        check("b2b_second_data",  od_log[8],          32'h00205000);
        check("b2b_single_out",   {31'd0, ov_log[9]}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
